neo_frame_arbiter: RTL and testbench

Round-robin arbiter that shares one NeoPixel strip controller between NUM_REQ pattern producers. Each producer requests the strip, and the granted producer owns the controller's load and send port for exactly one frame: loads, one send, and the latch wait. The arbiter muxes the owner's load/send strobes and color data onto the controller. It also gates the controller's ready/done handshakes back to the owner only. It sits between the producer FSMs and the strip controller in the top level.

---
 rtl/neo_frame_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_neo_frame_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/neo_frame_arbiter.sv
// Round-robin owner arbiter sharing one NeoPixel strip controller between NUM_REQ producers.
// Optional idle-owner watchdog is enabled by defining NEO_ARB_TIMEOUT_EN.
module neo_frame_arbiter #(
    parameter int          NUM_REQ = 2,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     p_load_color,
    input  logic [NUM_REQ-1:0]     p_send_it,
    input  logic [3*NUM_REQ-1:0]   p_pixel_index,
    input  logic [2*NUM_REQ-1:0]   p_color_index,
    input  logic [8*NUM_REQ-1:0]   p_color_level,
    input  logic                   ready_to_load,
    input  logic                   ready_to_send,
    input  logic                   done_wait,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     p_ready_to_load,
    output logic [NUM_REQ-1:0]     p_ready_to_send,
    output logic [NUM_REQ-1:0]     p_done,
    output logic                   load_color,
    output logic                   send_it,
    output logic [2:0]             pixel_index,
    output logic [1:0]             color_index,
    output logic [7:0]             color_level,
    output logic [15:0]            frame_count,
    output logic                   timeout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_SENDING = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            oh[i] = (IDX_W'(i) == idx);
        end
        return oh;
    endfunction

    state_t               state_r, next_state_s;
    logic [IDX_W-1:0]     owner_r, last_r, win_idx_s, cand_idx_s;
    logic                 win_found_s, timeout_hit_s, wd_expire_s;
    logic [NUM_REQ-1:0]   grant_r, p_done_r;
    logic                 timeout_r;
    logic [15:0]          frame_count_r;
    logic                 load_color_s, send_it_s;
    logic [2:0]           pixel_index_s;
    logic [1:0]           color_index_s;
    logic [7:0]           color_level_s;
    int                   cand_s;

    logic [2:0] pix_arr_s [NUM_REQ];
    logic [1:0] cidx_arr_s [NUM_REQ];
    logic [7:0] lvl_arr_s [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign pix_arr_s[g]  = p_pixel_index[3*g +: 3];
        assign cidx_arr_s[g] = p_color_index[2*g +: 2];
        assign lvl_arr_s[g]  = p_color_level[8*g +: 8];
    end

    // Round-robin search starting one past the last owner
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IDX_W{1'b0}};
        cand_s      = 0;
        cand_idx_s  = {IDX_W{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s      = (int'(last_r) + k) % NUM_REQ;
            cand_idx_s  = IDX_W'(cand_s);
            win_idx_s   = (!win_found_s && req[cand_idx_s]) ? cand_idx_s : win_idx_s;
            win_found_s = win_found_s | req[cand_idx_s];
        end
    end

`ifdef NEO_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt_r;

    // Idle-owner watchdog: restarts on OWN entry and on every forwarded load
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt_r <= 16'd0;
        end else if (state_r != ST_OWN || load_color_s) begin
            wd_cnt_r <= 16'd0;
        end else begin
            wd_cnt_r <= wd_cnt_r + 16'd1;
        end
    end

    assign wd_expire_s = (state_r == ST_OWN) && (wd_cnt_r == (TIMEOUT - 16'd1));
`else
    assign wd_expire_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; a forwarded send takes priority over a dropped request
    always_comb begin
        next_state_s  = state_r;
        timeout_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) next_state_s = ST_OWN;
                else             next_state_s = ST_IDLE;
            end
            ST_OWN: begin
                if (send_it_s) begin
                    next_state_s = ST_SENDING;
                end else if (!req[owner_r]) begin
                    next_state_s = ST_RELEASE;
                end else if (wd_expire_s) begin
                    next_state_s  = ST_RELEASE;
                    timeout_hit_s = 1'b1;
                end else begin
                    next_state_s = ST_OWN;
                end
            end
            ST_SENDING: begin
                if (done_wait) next_state_s = ST_RELEASE;
                else           next_state_s = ST_SENDING;
            end
            ST_RELEASE: next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: owner strobes and data pass straight through only while in OWN
    always_comb begin
        load_color_s  = 1'b0;
        send_it_s     = 1'b0;
        pixel_index_s = 3'd0;
        color_index_s = 2'd0;
        color_level_s = 8'd0;
        if (state_r == ST_OWN) begin
            load_color_s = p_load_color[owner_r] & ready_to_load;
            send_it_s    = p_send_it[owner_r] & ready_to_send;
            if (load_color_s) begin
                pixel_index_s = pix_arr_s[owner_r];
                color_index_s = cidx_arr_s[owner_r];
                color_level_s = lvl_arr_s[owner_r];
            end else begin
                pixel_index_s = 3'd0;
                color_index_s = 2'd0;
                color_level_s = 8'd0;
            end
        end else begin
            load_color_s = 1'b0;
            send_it_s    = 1'b0;
        end
    end

    // Ownership bookkeeping, release pulses and frame counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_r       <= {IDX_W{1'b0}};
            last_r        <= IDX_W'(NUM_REQ - 1);
            grant_r       <= {NUM_REQ{1'b0}};
            p_done_r      <= {NUM_REQ{1'b0}};
            timeout_r     <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            p_done_r  <= (next_state_s == ST_RELEASE) ? idx_to_onehot(owner_r) : {NUM_REQ{1'b0}};
            timeout_r <= timeout_hit_s;
            if (state_r == ST_IDLE && win_found_s) begin
                owner_r <= win_idx_s;
                grant_r <= idx_to_onehot(win_idx_s);
            end else if (next_state_s == ST_RELEASE) begin
                grant_r <= {NUM_REQ{1'b0}};
            end else begin
                grant_r <= grant_r;
            end
            if (state_r == ST_RELEASE) begin
                last_r <= owner_r;
            end else begin
                last_r <= last_r;
            end
            if (state_r == ST_SENDING && done_wait) begin
                frame_count_r <= frame_count_r + 16'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign grant           = grant_r;
    assign p_done          = p_done_r;
    assign timeout         = timeout_r;
    assign frame_count     = frame_count_r;
    assign p_ready_to_load = grant_r & {NUM_REQ{ready_to_load}};
    assign p_ready_to_send = grant_r & {NUM_REQ{ready_to_send}};
    assign load_color      = load_color_s;
    assign send_it         = send_it_s;
    assign pixel_index     = pixel_index_s;
    assign color_index     = color_index_s;
    assign color_level     = color_level_s;

endmodule

// File: tb/tb_neo_frame_arbiter.sv
// Directed, table-driven bench for neo_frame_arbiter with two producers.
// Watchdog expectations follow NEO_ARB_TIMEOUT_EN (TIMEOUT=16 here).
module tb_neo_frame_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  req, p_load_color, p_send_it;
    logic [5:0]  p_pixel_index;
    logic [3:0]  p_color_index;
    logic [15:0] p_color_level;
    logic        ready_to_load, ready_to_send, done_wait;
    logic [1:0]  grant, p_ready_to_load, p_ready_to_send, p_done;
    logic        load_color, send_it, timeout;
    logic [2:0]  pixel_index;
    logic [1:0]  color_index;
    logic [7:0]  color_level;
    logic [15:0] frame_count;

    int checks   = 0;
    int failures = 0;
    int load_cnt = 0;

    neo_frame_arbiter #(.NUM_REQ(2), .TIMEOUT(16'd16)) dut (
        .clock(clock), .reset(reset), .req(req),
        .p_load_color(p_load_color), .p_send_it(p_send_it),
        .p_pixel_index(p_pixel_index), .p_color_index(p_color_index),
        .p_color_level(p_color_level), .ready_to_load(ready_to_load),
        .ready_to_send(ready_to_send), .done_wait(done_wait),
        .grant(grant), .p_ready_to_load(p_ready_to_load),
        .p_ready_to_send(p_ready_to_send), .p_done(p_done),
        .load_color(load_color), .send_it(send_it),
        .pixel_index(pixel_index), .color_index(color_index),
        .color_level(color_level), .frame_count(frame_count), .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (load_color) load_cnt <= load_cnt + 1;
    end

    typedef struct packed {
        logic [1:0]  req;
        logic [1:0]  pl;
        logic [1:0]  ps;
        logic        rtl;
        logic        rts;
        logic        dw;
        logic [1:0]  e_grant;
        logic        e_load;
        logic        e_send;
        logic [2:0]  e_pix;
        logic [1:0]  e_cidx;
        logic [7:0]  e_lvl;
        logic [1:0]  e_prtl;
        logic [1:0]  e_prts;
        logic [1:0]  e_pdone;
        logic [15:0] e_fc;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        req = 2'b00; p_load_color = 2'b00; p_send_it = 2'b00;
        p_pixel_index = {3'd1, 3'd5}; p_color_index = {2'd1, 2'd2};
        p_color_level = {8'h3C, 8'hA5};
        ready_to_load = 1'b0; ready_to_send = 1'b0; done_wait = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        #1;
        chk("reset_state",
            {22'd0, grant, p_ready_to_load, p_ready_to_send, p_done, load_color, send_it,
             pixel_index, color_index, color_level, frame_count, timeout},
            64'd0);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time bound expired");
    end

    initial begin
        logic [39:0] act_v, exp_v;
        logic [12:0] exp_data;

        //          req    pl     ps     rtl   rts   dw    grant  ld    sd    pix   cidx  lvl     prtl   prts   pdone  fc
        vecs[0]  = '{2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 2'b00, 2'b00, 2'b00, 16'd0};
        vecs[1]  = '{2'b11, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 2'b01, 2'b01, 2'b00, 16'd0};
        vecs[2]  = '{2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 3'd5, 2'd2, 8'hA5, 2'b01, 2'b00, 2'b00, 16'd0};
        vecs[3]  = '{2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 2'b00, 2'b00, 2'b00, 16'd0};
        vecs[4]  = '{2'b11, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 3'd0, 2'd0, 8'h00, 2'b00, 2'b01, 2'b00, 16'd0};
        vecs[5]  = '{2'b11, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 2'b01, 2'b01, 2'b00, 16'd0};
        vecs[6]  = '{2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 2'b00, 2'b00, 2'b00, 16'd0};
        vecs[7]  = '{2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 2'b00, 2'b00, 2'b01, 16'd1};
        vecs[8]  = '{2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 2'b00, 2'b00, 2'b00, 16'd1};
        vecs[9]  = '{2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 3'd1, 2'd1, 8'h3C, 2'b10, 2'b00, 2'b00, 16'd1};
        vecs[10] = '{2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 2'b00, 2'b00, 2'b00, 16'd1};
        vecs[11] = '{2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 2'b00, 2'b00, 2'b10, 16'd1};
        vecs[12] = '{2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 2'b00, 2'b00, 2'b00, 16'd1};
        vecs[13] = '{2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 2'b00, 2'b00, 2'b00, 16'd1};

        reset_dut();
        for (int i = 0; i < 14; i++) begin
            req = vecs[i].req; p_load_color = vecs[i].pl; p_send_it = vecs[i].ps;
            ready_to_load = vecs[i].rtl; ready_to_send = vecs[i].rts; done_wait = vecs[i].dw;
            #1;
            act_v = {grant, load_color, send_it, pixel_index, color_index, color_level,
                     p_ready_to_load, p_ready_to_send, p_done, frame_count, timeout};
            exp_v = {vecs[i].e_grant, vecs[i].e_load, vecs[i].e_send, vecs[i].e_pix,
                     vecs[i].e_cidx, vecs[i].e_lvl, vecs[i].e_prtl, vecs[i].e_prts,
                     vecs[i].e_pdone, vecs[i].e_fc, 1'b0};
            if (act_v !== exp_v) $display("vector %0d differs", i);
            chk("table_vector", {24'd0, act_v}, {24'd0, exp_v});
            next_cycle();
        end

        // Full frame: five loads, send, done_wait 20 cycles after the send
        reset_dut();
        req = 2'b11;
        #1; chk("ff_grant_before", {62'd0, grant}, 64'd0);
        next_cycle();
        chk("ff_grant_owner0", {62'd0, grant}, 64'd1);
        load_cnt = 0;
        ready_to_load = 1'b1; ready_to_send = 1'b1;
        for (int i = 0; i < 5; i++) begin
            p_load_color = 2'b01;
            p_pixel_index = {3'd7, 3'(i)};
            p_color_index = {2'd3, 2'(i)};
            p_color_level = {8'hFF, 8'(8'h10 + i)};
            exp_data = {3'(i), 2'(i), 8'(8'h10 + i)};
            #1;
            chk("ff_load_strobe", {63'd0, load_color}, 64'd1);
            chk("ff_load_data", {51'd0, pixel_index, color_index, color_level}, {51'd0, exp_data});
            next_cycle();
        end
        p_load_color = 2'b00; p_send_it = 2'b01;
        #1; chk("ff_send", {63'd0, send_it}, 64'd1);
        next_cycle();
        p_send_it = 2'b00; p_load_color = 2'b11;
        for (int i = 0; i < 19; i++) begin
            #1; chk("ff_sending_quiet", {62'd0, load_color, send_it}, 64'd0);
            next_cycle();
        end
        p_load_color = 2'b00; done_wait = 1'b1;
        next_cycle();
        done_wait = 1'b0;
        chk("ff_release", {44'd0, grant, p_done, frame_count}, {44'd0, 2'b00, 2'b01, 16'd1});
        chk("ff_load_count", 64'(load_cnt), 64'd5);
        next_cycle();
        chk("ff_idle_gap", {60'd0, grant, p_done}, 64'd0);
        next_cycle();
        chk("ff_next_owner1", {62'd0, grant}, 64'd2);

        // Send blocked, then forwarded; then reset mid-frame
        reset_dut();
        req = 2'b01;
        next_cycle();
        p_send_it = 2'b01; ready_to_send = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1; chk("sb_blocked", {61'd0, grant, send_it}, {61'd0, 2'b01, 1'b0});
            next_cycle();
        end
        ready_to_send = 1'b1;
        #1; chk("sb_forward", {63'd0, send_it}, 64'd1);
        next_cycle();
        req = 2'b00;
        #1; chk("sb_sending_gated", {61'd0, grant, send_it}, {61'd0, 2'b01, 1'b0});
        next_cycle();
        chk("sb_req_ignored", {62'd0, grant}, 64'd1);
        reset = 1'b0;
        #1; chk("sb_midframe_reset", {45'd0, grant, send_it, frame_count}, 64'd0);
        reset = 1'b1;
        clear_inputs();
        next_cycle();

        // Watchdog: owner holds req without loading or sending
        reset_dut();
        req = 2'b01;
        next_cycle();
`ifdef NEO_ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            #1; chk("wd_owned", {61'd0, grant, timeout}, {61'd0, 2'b01, 1'b0});
            next_cycle();
        end
        #1; chk("wd_fire", {43'd0, timeout, p_done, grant, frame_count}, {43'd0, 1'b1, 2'b01, 2'b00, 16'd0});
`else
        for (int i = 0; i < 100; i++) begin
            #1; chk("wd_absent_hold", {61'd0, grant, timeout}, {61'd0, 2'b01, 1'b0});
            next_cycle();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
